// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline-side and memory-side signals of the memory-stage
// access controller. The master modport is the controller; the slave modport
// is the environment (pipeline + data memory) driving it.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Pipeline request side
    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [1:0]        in_size;
    logic              in_sign;
    logic [ADDR_W-1:0] alu_result;
    logic [DATA_W-1:0] rt_reg_content;

    // Data memory side
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Writeback side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rdata;
    logic              out_err;

    modport master (
        input  in_valid, in_we, in_size, in_sign, alu_result, rt_reg_content,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  out_ready,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output out_valid, out_rdata, out_err
    );

    modport slave (
        output in_valid, in_we, in_size, in_sign, alu_result, rt_reg_content,
        output mem_gnt, mem_rvalid, mem_rdata,
        output out_ready,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  out_valid, out_rdata, out_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: registered, handshaked memory-stage access controller.
// Latches an effective address and store data, issues one sized, byte-strobed
// request to data memory, waits (bounded by MAX_WAIT) for the response and
// returns sign/zero-extended load data or an error to writeback.
// Optional feature macro: MEM_UNALIGNED_TRAP_EN -- when defined, misaligned
// accesses complete immediately with out_err=1 instead of being force-aligned.
module mem_access_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              resetn,
    mem_access_ctrl_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic              r_sign;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_out_rdata;
    logic              r_out_err;

    logic [OFF_W-1:0]  w_off_raw;
    logic [OFF_W-1:0]  w_align_mask;
    logic [OFF_W-1:0]  w_off;
    logic              w_size_ok;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_timeout;

    // Byte-lane strobe: (1 << 2^size) - 1 shifted up to the lane offset.
    function automatic logic [STRB_W-1:0] f_strb(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [15:0] w_m;
        case (size)
            2'd0:    w_m = 16'h0001;
            2'd1:    w_m = 16'h0003;
            2'd2:    w_m = 16'h000F;
            default: w_m = 16'h00FF;
        endcase
        return STRB_W'(w_m << off);
    endfunction

    // Replicate the low 2^size bytes of the store data across every lane.
    function automatic logic [DATA_W-1:0] f_wdata(input logic [DATA_W-1:0] rt, input logic [1:0] size);
        logic [DATA_W-1:0] w_d;
        int                w_nb;
        w_nb = 1 << size;
        w_d  = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_d[8*i +: 8] = rt[8*(i & (w_nb - 1)) +: 8];
        end
        return w_d;
    endfunction

    // Right-justify the addressed lanes of the beat, then sign/zero-extend.
    function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] rdata, input logic [OFF_W-1:0] off,
                                                   input logic [1:0] size, input logic sign);
        logic [DATA_W-1:0] w_sh;
        logic              w_ext;
        int                w_bits;
        w_sh   = rdata >> {off, 3'b000};
        w_bits = 8 << size;
        case (size)
            2'd0:    w_ext = sign & w_sh[7];
            2'd1:    w_ext = sign & w_sh[15];
            2'd2:    w_ext = sign & w_sh[31];
            default: w_ext = sign & w_sh[DATA_W-1];
        endcase
        for (int j = 0; j < DATA_W; j++) begin
            if (j >= w_bits) w_sh[j] = w_ext;
        end
        return w_sh;
    endfunction

    // Accept-time decode: lane offset, size legality and alignment policy.
    always_comb begin
        w_off_raw    = bus.alu_result[OFF_W-1:0];
        w_align_mask = OFF_W'((4'b0001 << bus.in_size) - 4'b0001);
        w_size_ok    = (bus.in_size != 2'd3) || (DATA_W == 64);
`ifdef MEM_UNALIGNED_TRAP_EN
        w_misaligned = |(w_off_raw & w_align_mask);
        w_off        = w_off_raw;
`else
        w_misaligned = 1'b0;
        w_off        = w_off_raw & ~w_align_mask;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_timeout     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_size_ok && !w_misaligned) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == 8'(MAX_WAIT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the access, build the request, capture the result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_size      <= '0;
            r_off       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_out_rdata <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.in_we;
                        r_sign      <= bus.in_sign;
                        r_size      <= bus.in_size;
                        r_off       <= w_off;
                        r_out_rdata <= '0;
                        r_out_err   <= !w_size_ok || w_misaligned;
                        if (w_size_ok && !w_misaligned) begin
                            r_mem_we    <= bus.in_we;
                            r_mem_addr  <= {bus.alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_wstrb <= f_strb(bus.in_size, w_off);
                            r_mem_wdata <= bus.in_we ? f_wdata(bus.rt_reg_content, bus.in_size) : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt) r_cnt <= '0;
                end
                S_RESP: begin
                    if (bus.mem_rvalid) begin
                        r_out_rdata <= r_we ? '0 : f_extend(bus.mem_rdata, r_off, r_size, r_sign);
                        r_out_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_timeout) begin
                            r_out_rdata <= '0;
                            r_out_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.out_rdata = r_out_rdata;
    assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl. Stimulus tasks push
// the expected memory request and writeback result into queues; a monitor on
// the falling edge pops and compares whenever a DUT request is granted or a
// result appears. A 32-bit and a 64-bit instance run one after the other.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    mem_access_ctrl_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(15)) u_dut32 (.clk(clk), .resetn(resetn), .bus(b32));
    mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(15)) u_dut64 (.clk(clk), .resetn(resetn), .bus(b64));

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        int          len;
    } req_t;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    int   acc_cyc  [2];
    bit   rst_seen [2];
    bit   req_act  [2];
    int   req_len  [2];
    req_t req_cap  [2];
    bit   ov_act   [2];
    res_t res_cap  [2];

    function automatic req_t mk_req(input logic we, input logic [63:0] a, input logic [7:0] s,
                                    input logic [63:0] d, input int len);
        req_t r;
        r.we = we; r.addr = a; r.strb = s; r.wdata = d; r.len = len;
        return r;
    endfunction

    function automatic res_t mk_res(input logic err, input logic [63:0] d, input int lat);
        res_t r;
        r.err = err; r.rdata = d; r.lat = lat;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor / scoreboard for one instance, evaluated mid-cycle.
    task automatic mon_step(input int id, input logic iv, input logic ir, input logic mreq, input logic mgnt,
                            input logic mwe, input logic [63:0] maddr, input logic [7:0] mstrb,
                            input logic [63:0] mwdata, input logic ov, input logic ordy,
                            input logic oerr, input logic [63:0] ordata);
        req_t er;
        res_t es;
        if (rst_seen[id]) begin
            check($sformatf("reset_ctrl_%0d", id), 64'({ir, mreq, mwe, ov, oerr}), 64'h10);
            check($sformatf("reset_data_%0d", id), maddr | 64'(mstrb) | mwdata | ordata, 64'h0);
            req_act[id] = 1'b0;
            ov_act[id]  = 1'b0;
            return;
        end
        if (resetn && iv && ir) acc_cyc[id] = cyc + 1;
        if (mreq) begin
            if (!req_act[id]) begin
                req_act[id] = 1'b1;
                req_len[id] = 0;
                req_cap[id] = mk_req(mwe, maddr, mstrb, mwdata, 0);
            end
            req_len[id]++;
            if (mgnt) begin
                check("req_stable", 64'(mwe != req_cap[id].we || maddr != req_cap[id].addr ||
                                        mstrb != req_cap[id].strb || mwdata != req_cap[id].wdata), 64'h0);
                check("req_expected", 64'(req_q.size() != 0), 64'h1);
                if (req_q.size() != 0) begin
                    er = req_q.pop_front();
                    check("mem_addr", maddr, er.addr);
                    check("mem_wstrb", 64'(mstrb), 64'(er.strb));
                    check("mem_wdata", mwdata, er.wdata);
                    check("mem_we", 64'(mwe), 64'(er.we));
                    check("req_cycles", 64'(req_len[id]), 64'(er.len));
                end
                req_act[id] = 1'b0;
            end
        end
        if (ov) begin
            if (!ov_act[id]) begin
                ov_act[id]  = 1'b1;
                res_cap[id] = mk_res(oerr, ordata, cyc - acc_cyc[id]);
                check("res_expected", 64'(res_q.size() != 0), 64'h1);
                if (res_q.size() != 0) begin
                    es = res_q.pop_front();
                    check("out_err", 64'(oerr), 64'(es.err));
                    check("out_rdata", ordata, es.rdata);
                    check("latency", 64'(cyc - acc_cyc[id]), 64'(es.lat));
                end
            end else begin
                check("out_hold", 64'(oerr != res_cap[id].err || ordata != res_cap[id].rdata), 64'h0);
            end
            if (ordy) ov_act[id] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_seen[0] <= !resetn;
        rst_seen[1] <= !resetn;
    end

    always @(negedge clk) begin
        mon_step(0, b32.in_valid, b32.in_ready, b32.mem_req, b32.mem_gnt, b32.mem_we, 64'(b32.mem_addr),
                 8'(b32.mem_wstrb), 64'(b32.mem_wdata), b32.out_valid, b32.out_ready, b32.out_err,
                 64'(b32.out_rdata));
        mon_step(1, b64.in_valid, b64.in_ready, b64.mem_req, b64.mem_gnt, b64.mem_we, 64'(b64.mem_addr),
                 b64.mem_wstrb, b64.mem_wdata, b64.out_valid, b64.out_ready, b64.out_err, b64.out_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int id, input logic v, input logic we, input logic [1:0] sz, input logic sg,
                            input logic [63:0] addr, input logic [63:0] rt);
        if (id == 0) begin
            b32.in_valid = v; b32.in_we = we; b32.in_size = sz; b32.in_sign = sg;
            b32.alu_result = addr[31:0]; b32.rt_reg_content = rt[31:0];
        end else begin
            b64.in_valid = v; b64.in_we = we; b64.in_size = sz; b64.in_sign = sg;
            b64.alu_result = addr[31:0]; b64.rt_reg_content = rt;
        end
    endtask

    task automatic set_gnt(input int id, input logic v);
        if (id == 0) b32.mem_gnt = v; else b64.mem_gnt = v;
    endtask

    task automatic set_rv(input int id, input logic v, input logic [63:0] d);
        if (id == 0) begin b32.mem_rvalid = v; b32.mem_rdata = d[31:0]; end
        else begin b64.mem_rvalid = v; b64.mem_rdata = d; end
    endtask

    task automatic set_rdy(input int id, input logic v);
        if (id == 0) b32.out_ready = v; else b64.out_ready = v;
    endtask

    function automatic logic get_ov(input int id);
        return (id == 0) ? b32.out_valid : b64.out_valid;
    endfunction

    // One access: g = cycles of withheld grant, r = cycles before rvalid
    // (negative: never), rdy = cycles out_ready is held low once out_valid is up.
    task automatic run_access(input int id, input logic we, input logic [1:0] sz, input logic sg,
                              input logic [63:0] addr, input logic [63:0] rt, input int g, input int r,
                              input logic [63:0] rdata, input int rdy, input bit has_req,
                              input req_t er, input res_t es);
        int k;
        if (has_req) req_q.push_back(er);
        res_q.push_back(es);
        drive_in(id, 1'b1, we, sz, sg, addr, rt);
        step();
        drive_in(id, 1'b0, we, sz, sg, addr, rt);
        if (has_req) begin
            repeat (g) step();
            set_gnt(id, 1'b1); step(); set_gnt(id, 1'b0);
            if (r >= 0) begin
                repeat (r) step();
                set_rv(id, 1'b1, rdata); step(); set_rv(id, 1'b0, 64'h0);
            end
        end
        k = 0;
        while (!get_ov(id) && k < 400) begin step(); k++; end
        check("out_valid_seen", 64'(get_ov(id)), 64'h1);
        if (has_req && r < 0) set_rv(id, 1'b1, 64'hFFFF_FFFF_5555_AAAA);
        step();
        set_rv(id, 1'b0, 64'h0);
        repeat (rdy) step();
        set_rdy(id, 1'b1); step(); set_rdy(id, 1'b0);
        if (has_req && r < 0) begin
            set_rv(id, 1'b1, 64'h1111_2222_3333_4444); step(); set_rv(id, 1'b0, 64'h0);
        end
    endtask

    initial begin
        drive_in(0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
        drive_in(1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
        set_gnt(0, 1'b0); set_gnt(1, 1'b0);
        set_rv(0, 1'b0, 64'h0); set_rv(1, 1'b0, 64'h0);
        set_rdy(0, 1'b0); set_rdy(1, 1'b0);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        step();

        // Store half at 0x1000_0006: aligned, upper half lanes, data replicated.
        run_access(0, 1'b1, 2'd1, 1'b0, 64'h1000_0006, 64'h1234_ABCD, 0, 0, 64'h0, 0, 1'b1,
                   mk_req(1'b1, 64'h1000_0004, 8'hC, 64'hABCD_ABCD, 1), mk_res(1'b0, 64'h0, 2));
        // Load byte from lane 3, signed then unsigned.
        run_access(0, 1'b0, 2'd0, 1'b1, 64'h2000_0003, 64'h0, 0, 0, 64'h80FF_0000, 0, 1'b1,
                   mk_req(1'b0, 64'h2000_0000, 8'h8, 64'h0, 1), mk_res(1'b0, 64'hFFFF_FF80, 2));
        run_access(0, 1'b0, 2'd0, 1'b0, 64'h2000_0003, 64'h0, 0, 0, 64'h80FF_0000, 0, 1'b1,
                   mk_req(1'b0, 64'h2000_0000, 8'h8, 64'h0, 1), mk_res(1'b0, 64'h0000_0080, 2));
        // Misaligned signed half load from offset 1.
`ifdef MEM_UNALIGNED_TRAP_EN
        run_access(0, 1'b0, 2'd1, 1'b1, 64'h3000_0001, 64'h0, 0, 0, 64'h0000_BEEF, 0, 1'b0,
                   mk_req(1'b0, 64'h0, 8'h0, 64'h0, 0), mk_res(1'b1, 64'h0, 0));
`else
        run_access(0, 1'b0, 2'd1, 1'b1, 64'h3000_0001, 64'h0, 0, 0, 64'h0000_BEEF, 0, 1'b1,
                   mk_req(1'b0, 64'h3000_0000, 8'h3, 64'h0, 1), mk_res(1'b0, 64'hFFFF_BEEF, 2));
`endif
        // Word load ignores in_sign; grant and response delayed, writeback stalls.
        run_access(0, 1'b0, 2'd2, 1'b1, 64'h4000_0008, 64'h0, 2, 3, 64'h8765_4321, 2, 1'b1,
                   mk_req(1'b0, 64'h4000_0008, 8'hF, 64'h0, 3), mk_res(1'b0, 64'h8765_4321, 7));
        // Unsigned half from the upper lanes.
        run_access(0, 1'b0, 2'd1, 1'b0, 64'h4000_0002, 64'h0, 0, 0, 64'hCAFE_0000, 0, 1'b1,
                   mk_req(1'b0, 64'h4000_0000, 8'hC, 64'h0, 1), mk_res(1'b0, 64'h0000_CAFE, 2));
        // Store byte into lane 1.
        run_access(0, 1'b1, 2'd0, 1'b0, 64'h5000_0001, 64'hFFFF_FF5A, 0, 0, 64'h0, 0, 1'b1,
                   mk_req(1'b1, 64'h5000_0000, 8'h2, 64'h5A5A_5A5A, 1), mk_res(1'b0, 64'h0, 2));
        // Dword on a 32-bit path is illegal: immediate error, no request.
        run_access(0, 1'b0, 2'd3, 1'b0, 64'h5000_0000, 64'h0, 0, 0, 64'h0, 1, 1'b0,
                   mk_req(1'b0, 64'h0, 8'h0, 64'h0, 0), mk_res(1'b1, 64'h0, 0));
        // Grant withheld 5 cycles, response never arrives: timeout 15 cycles after grant.
        run_access(0, 1'b0, 2'd2, 1'b0, 64'h6000_0000, 64'h0, 5, -1, 64'h0, 3, 1'b1,
                   mk_req(1'b0, 64'h6000_0000, 8'hF, 64'h0, 6), mk_res(1'b1, 64'h0, 21));

        // Reset while waiting in RESP, then a stray response that must be ignored.
        req_q.push_back(mk_req(1'b0, 64'h7000_0000, 8'hF, 64'h0, 1));
        drive_in(0, 1'b1, 1'b0, 2'd2, 1'b1, 64'h7000_0000, 64'h0);
        step();
        drive_in(0, 1'b0, 1'b0, 2'd2, 1'b1, 64'h7000_0000, 64'h0);
        set_gnt(0, 1'b1); step(); set_gnt(0, 1'b0);
        step();
        resetn = 1'b0; step(); resetn = 1'b1;
        set_rv(0, 1'b1, 64'h1234_5678); step(); set_rv(0, 1'b0, 64'h0);
        repeat (5) step();

        // Recovery after reset.
        run_access(0, 1'b0, 2'd0, 1'b1, 64'h2000_0002, 64'h0, 0, 0, 64'h0080_0000, 0, 1'b1,
                   mk_req(1'b0, 64'h2000_0000, 8'h4, 64'h0, 1), mk_res(1'b0, 64'hFFFF_FF80, 2));

        // 64-bit path: dword store with writeback stalled 3 cycles.
        run_access(1, 1'b1, 2'd3, 1'b0, 64'h8, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0, 3, 1'b1,
                   mk_req(1'b1, 64'h8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1), mk_res(1'b0, 64'h0, 2));
        // 64-bit path: signed word load from the upper half of the beat.
        run_access(1, 1'b0, 2'd2, 1'b1, 64'h4, 64'h0, 1, 0, 64'h8000_0001_0000_0000, 0, 1'b1,
                   mk_req(1'b0, 64'h0, 8'hF0, 64'h0, 2), mk_res(1'b0, 64'hFFFF_FFFF_8000_0001, 3));

        repeat (4) step();
        check("req_queue_drained", 64'(req_q.size()), 64'h0);
        check("res_queue_drained", 64'(res_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
